// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - access-size and state encodings plus alignment helper for data_memory_bytewise
package data_memory_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = |addr_lo;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_memory_lane_select.sv
// rtl/data_memory_lane_select.sv - picks the addressed byte/half/word lane and right-aligns it
// with sign or zero extension.
module data_memory_lane_select
  import data_memory_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] i_word,
  input  logic [1:0]         i_lane,
  input  logic [1:0]         i_size,
  input  logic               i_unsigned,
  output logic [NB_DATA-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[8*i_lane +: 8];
  assign w_half = i_word[16*i_lane[1] +: 16];

  always_comb begin
    o_data = i_word;
    case (i_size)
      SIZE_BYTE: o_data = {{(NB_DATA-8){~i_unsigned & w_byte[7]}}, w_byte};
      SIZE_HALF: o_data = {{(NB_DATA-16){~i_unsigned & w_half[15]}}, w_half};
      default:   o_data = i_word;
    endcase
  end

endmodule

// File: rtl/data_memory_bytewise.sv
// rtl/data_memory_bytewise.sv - byte-addressable data memory with self-clearing after reset.
// Debug read port is present only when DATA_MEMORY_DEBUG_PORT_EN is defined.
module data_memory_bytewise
  import data_memory_pkg::*;
#(
  parameter int NB_ADDR   = 32,
  parameter int NB_DATA   = 32,
  parameter int RAM_DEPTH = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_write_enable,
  input  logic               i_read_enable,
  input  logic [NB_ADDR-1:0] i_address,
  input  logic [1:0]         i_size,
  input  logic               i_unsigned,
  input  logic [NB_DATA-1:0] i_data,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_read_valid,
  output logic               o_misaligned,
  output logic               o_busy
`ifdef DATA_MEMORY_DEBUG_PORT_EN
  ,
  input  logic [NB_ADDR-1:0] i_debug_address,
  output logic [NB_DATA-1:0] o_debug_data
`endif
);

  localparam int NB_IDX = $clog2(RAM_DEPTH);

  state_e r_state;
  state_e w_next_state;

  logic [NB_DATA-1:0] r_mem [RAM_DEPTH];
  logic [NB_IDX-1:0]  r_clear_count;
  logic [NB_DATA-1:0] r_data;
  logic               r_read_valid;
  logic               r_misaligned;

  logic [NB_IDX-1:0]  w_index;
  logic               w_clear_last;
  logic               w_accept;
  logic               w_bad;
  logic               w_store_ok;
  logic [NB_DATA-1:0] w_lane_data;

  // Upper address bits only select beyond the array, so they wrap away.
`ifdef DATA_MEMORY_DEBUG_PORT_EN
  logic [NB_ADDR-NB_IDX-2+NB_ADDR-NB_IDX+1:0] w_unused_addr;
  assign w_unused_addr = {i_address[NB_ADDR-1:NB_IDX+2],
                          i_debug_address[NB_ADDR-1:NB_IDX+2], i_debug_address[1:0]};
`else
  logic [NB_ADDR-NB_IDX-3:0] w_unused_addr;
  assign w_unused_addr = i_address[NB_ADDR-1:NB_IDX+2];
`endif

  assign w_index      = i_address[NB_IDX+1:2];
  assign w_clear_last = (r_clear_count == NB_IDX'(RAM_DEPTH-1));
  assign w_accept     = (r_state == ST_IDLE) && (i_write_enable || i_read_enable);
  assign w_bad        = is_misaligned(i_size, i_address[1:0]);
  assign w_store_ok   = w_accept && i_write_enable && !w_bad;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_CLEAR;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_CLEAR: if (w_clear_last) w_next_state = ST_IDLE;
      ST_IDLE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_CLEAR;
    endcase
  end

  always_comb begin
    o_busy = (r_state == ST_CLEAR);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset)                  r_clear_count <= '0;
    else if (r_state == ST_CLEAR) r_clear_count <= r_clear_count + 1'b1;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_clear_count] <= '0;
      end else if (w_store_ok) begin
        case (i_size)
          SIZE_BYTE: r_mem[w_index][8*i_address[1:0] +: 8]  <= i_data[7:0];
          SIZE_HALF: r_mem[w_index][16*i_address[1] +: 16]  <= i_data[15:0];
          default:   r_mem[w_index]                         <= i_data;
        endcase
      end
    end
  end

  data_memory_lane_select #(
    .NB_DATA (NB_DATA)
  ) u_lane_select (
    .i_word     (r_mem[w_index]),
    .i_lane     (i_address[1:0]),
    .i_size     (i_size),
    .i_unsigned (i_unsigned),
    .o_data     (w_lane_data)
  );

  // The read samples the array before this edge's store lands: read-first.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_data       <= '0;
      r_read_valid <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_read_valid <= w_accept && i_read_enable;
      r_misaligned <= w_accept && w_bad;
      if (w_accept && i_read_enable) r_data <= w_bad ? '0 : w_lane_data;
    end
  end

  assign o_data       = r_data;
  assign o_read_valid = r_read_valid;
  assign o_misaligned = r_misaligned;

`ifdef DATA_MEMORY_DEBUG_PORT_EN
  logic [NB_DATA-1:0] r_debug_data;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_debug_data <= '0;
    else         r_debug_data <= r_mem[i_debug_address[NB_IDX+1:2]];
  end

  assign o_debug_data = r_debug_data;
`endif

endmodule

// File: doc/data_memory_bytewise.md
DATA_MEMORY_BYTEWISE -- requirements
Module: data_memory_bytewise

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NB_ADDR, 32, byte-address width.
- NB_DATA, 32, word width; a multiple of 8.
- RAM_DEPTH, 32, number of words; a power of 2.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- i_clock, in, 1, sole clock; everything on the rising edge.
- i_reset, in, 1, synchronous, active-high reset.
- i_write_enable, in, 1, store request.
- i_read_enable, in, 1, load request.
- i_address, in, NB_ADDR, byte address shared by read and write.
- i_size, in, 2, access size: 00 byte, 01 half, 10 word, 11 illegal.
- i_unsigned, in, 1, zero-extend loads when 1, sign-extend when 0.
- i_data, in, NB_DATA, store data, right-aligned.
- o_data, out, NB_DATA, registered load result.
- o_read_valid, out, 1, one-cycle pulse qualifying o_data.
- o_misaligned, out, 1, one-cycle pulse flagging a rejected access.
- o_busy, out, 1, high while clearing; requests are ignored.
- i_debug_address, in, NB_ADDR, debug word address (macro only).
- o_debug_data, out, NB_DATA, registered debug word (macro only).

Function
REQ-003 Word index SHALL be i_address[log2(RAM_DEPTH)+1:2]; upper bits are ignored, so addresses wrap modulo RAM_DEPTH words.
REQ-004 Byte lanes SHALL be little-endian: lane n holds bits [8n+7:8n]; the byte lane is i_address[1:0] and the half lane is i_address[1].
REQ-005 An access SHALL be accepted only in IDLE with i_write_enable or i_read_enable high.
REQ-006 Alignment SHALL be checked on every accepted access: a half needs i_address[0]=0; a word needs i_address[1:0]=0; i_size=11 is always illegal.
REQ-007 An accepted store SHALL update only its selected lanes, taken from the low byte or half of i_data; other lanes are unchanged.
REQ-008 An accepted load SHALL register the selected lanes, right-aligned and sign- or zero-extended per i_unsigned, into o_data with o_read_valid=1 on the next cycle (latency 1).
REQ-009 A rejected (misaligned or illegal) access SHALL write nothing; the next cycle gives o_misaligned=1, plus o_read_valid=1 with o_data=0 if it was a read.
REQ-010 With both enables high, the write SHALL be performed and the read SHALL return pre-write contents (read-first).
REQ-011 When no load is accepted, o_data SHALL hold its last value and o_read_valid SHALL be 0.
REQ-012 The state machine SHALL have two states:
- CLEAR: writes zero to word[counter] and increments counter; after writing word RAM_DEPTH-1 it moves to IDLE.
- IDLE: serves requests.
REQ-013 o_busy SHALL be 1 exactly while in CLEAR; requests made in CLEAR are dropped with no pulses.

Reset
REQ-014 While i_reset=1: state SHALL be CLEAR, counter 0, o_data 0, o_read_valid 0, o_misaligned 0, o_busy 1, o_debug_data 0.
REQ-015 After i_reset falls, CLEAR SHALL take exactly RAM_DEPTH cycles, and o_busy SHALL fall on the cycle IDLE is entered.
REQ-016 Reset asserted mid-clear or mid-access SHALL restart clearing at word 0; any pending valid or misaligned pulse SHALL be cancelled.

Configuration
REQ-017 Macro DATA_MEMORY_DEBUG_PORT_EN SHALL control the debug port.
- Defined: the debug ports exist; o_debug_data is word[i_debug_address index] one cycle later, independent of o_busy, and follows REQ-003 wrapping.
- Undefined: the debug ports and their logic are absent.

Structure
REQ-018 Package data_memory_pkg SHALL hold the i_size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the state encoding (ST_CLEAR, ST_IDLE).
REQ-019 Lane extraction and sign extension SHALL be one combinational sub-module, data_memory_lane_select.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Reset 1 cycle, release: o_busy high exactly 32 cycles; then a word read of every address returns 0x00000000.
- SW 0x11223344 @0x8, LB @0x9 signed: o_data 0x00000033 next cycle; SB 0xF0 @0xA, then LB @0xA signed: 0xFFFFFFF0; unsigned: 0x000000F0.
- SH 0x8001 @0x6, LH signed @0x6: 0xFFFF8001; LW @0x4: 0x80010000; write and read both high @0x4 with 0x0: read 0x80010000, next read 0x00000000.
- LW @0x2, SH @0x5, i_size=11: each gives an o_misaligned pulse, memory unchanged, and LW gives o_data 0 with valid.
- SW 0xDEADBEEF @0x80 (wraps to word 0), LW @0x0: 0xDEADBEEF; reset at clear cycle 10: o_busy lasts 32 more cycles.
- Macro defined: debug read word 0 during CLEAR and IDLE returns current contents after 1 cycle.
